// File: rtl/cpu_bus_sync.sv
// -----------------------------------------------------------------------------
// cpu_bus_sync
//
// Front-end stage between the asynchronous HuCard-slot CPU pins and the clk
// domain. Every pin passes through a SYNC_STAGES flop synchronizer. A small
// FSM then turns the synchronized strobes into clean access qualifiers (oe,
// we), one-shot pulses (oe_sync once per read, we_sync once per write), a
// frozen access address and latched write data.
//
// Parameters:
//   SYNC_STAGES  synchronizer depth on every pin input (2 or more)
//   WE_DLY       clk cycles from synchronized write start to we_sync, 1..15
//   FILT_LEN     consecutive equal strobe samples needed to accept a change
//                (present only in the glitch-filter build)
//
// Build option:
//   CPU_BUS_GLITCH_FILT_EN  when defined, oe_n/we_n/ce are debounced after
//                           the synchronizer; all strobe latencies grow by
//                           FILT_LEN-1 and shorter pulses are ignored.
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous reset, active high
//   cpu_addr  in   [20:0] CPU address pins (async)
//   cpu_dato  in   [7:0]  CPU write data pins (async)
//   cpu_oe_n  in   read strobe, active low (async)
//   cpu_we_n  in   write strobe, active low (async)
//   cpu_ce    in   cart select, active high (async)
//   cpu_hsm   in   high-speed-mode pin (async)
//   addr      out  [20:0] access address, stable for the whole access
//   data      out  [7:0]  write data, latched on the we_sync cycle
//   oe        out  read access in progress
//   we        out  write access in progress
//   oe_sync   out  1-cycle pulse at read start
//   we_sync   out  1-cycle pulse once write data has settled
//   hsm       out  synchronized cpu_hsm
//   busy      out  FSM not in IDLE
// -----------------------------------------------------------------------------
module cpu_bus_sync #(
    parameter int SYNC_STAGES = 2,
`ifdef CPU_BUS_GLITCH_FILT_EN
    parameter int FILT_LEN    = 3,
`endif
    parameter int WE_DLY      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [20:0] cpu_addr,
    input  logic [7:0]  cpu_dato,
    input  logic        cpu_oe_n,
    input  logic        cpu_we_n,
    input  logic        cpu_ce,
    input  logic        cpu_hsm,
    output logic [20:0] addr,
    output logic [7:0]  data,
    output logic        oe,
    output logic        we,
    output logic        oe_sync,
    output logic        we_sync,
    output logic        hsm,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_WAIT,
        WR_DONE,
        LOCK
    } state_t;

    // All pins travel together through one synchronizer chain.
    localparam int PW = 33;

    logic [PW-1:0] pins;
    logic [PW-1:0] pin_s;
    logic [PW-1:0] pin_sync_q [SYNC_STAGES];

    assign pins = {cpu_hsm, cpu_ce, cpu_we_n, cpu_oe_n, cpu_dato, cpu_addr};

    // NOTE: the synchronizer (and the strobe filter) is deliberately not reset:
    // it must keep sampling the pins while rst is high, so a strobe already
    // active at reset release is seen as active and parked in LOCK instead of
    // looking like a fresh edge.
    always_ff @(posedge clk) begin
        pin_sync_q[0] <= pins;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            pin_sync_q[i] <= pin_sync_q[i-1];
        end
    end

    assign pin_s = pin_sync_q[SYNC_STAGES-1];

    logic [20:0] addr_s;
    logic [7:0]  dato_s;
    logic        hsm_s;
    logic [2:0]  strb_raw;   // {ce, we_n, oe_n}
    logic [2:0]  strb;       // strobes as seen by the FSM

    assign addr_s   = pin_s[20:0];
    assign dato_s   = pin_s[28:21];
    assign strb_raw = pin_s[31:29];
    assign hsm_s    = pin_s[32];

`ifdef CPU_BUS_GLITCH_FILT_EN
    // Per-strobe debounce: filt_cnt_q counts consecutive earlier samples that
    // disagreed with the accepted value. The FILT_LEN-th disagreeing sample is
    // accepted combinationally, so the added latency is FILT_LEN-1 cycles.
    localparam int              FCW       = $clog2(FILT_LEN) + 1;
    localparam logic [FCW-1:0]  FILT_LAST = FCW'(FILT_LEN - 1);

    logic [2:0]     filt_q;
    logic [2:0]     filt_d;
    logic [FCW-1:0] filt_cnt_q [3];
    logic [FCW-1:0] filt_cnt_d [3];

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            filt_d[i]     = filt_q[i];
            filt_cnt_d[i] = '0;
            if (strb_raw[i] != filt_q[i]) begin
                if (filt_cnt_q[i] == FILT_LAST) begin
                    filt_d[i] = strb_raw[i];
                end else begin
                    filt_cnt_d[i] = filt_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        filt_q <= filt_d;
        for (int i = 0; i < 3; i++) begin
            filt_cnt_q[i] <= filt_cnt_d[i];
        end
    end

    assign strb = filt_d;
`else
    assign strb = strb_raw;
`endif

    logic rd_s;
    logic wr_s;

    assign rd_s = ~strb[0] & strb[2];
    assign wr_s = ~strb[1] & strb[2];

    localparam logic [3:0] DLY_LAST = 4'(WE_DLY - 1);

    state_t      state_q,   state_d;
    logic [3:0]  dly_cnt_q, dly_cnt_d;
    logic [20:0] addr_q,    addr_d;
    logic [7:0]  data_q,    data_d;
    logic        oe_q,      oe_d;
    logic        we_q,      we_d;
    logic        oe_sync_q, oe_sync_d;
    logic        we_sync_q, we_sync_d;
    logic        hsm_q,     hsm_d;
    logic        busy_q,    busy_d;

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        dly_cnt_d = dly_cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        oe_sync_d = 1'b0;
        we_sync_d = 1'b0;
        hsm_d     = hsm_s;

        unique case (state_q)
            IDLE: begin
                // Address follows the pins while idle and freezes on the
                // entry cycle of an access. Write wins over read.
                addr_d = addr_s;
                if (wr_s) begin
                    state_d   = WR_WAIT;
                    dly_cnt_d = '0;
                end else if (rd_s) begin
                    state_d   = RD;
                    oe_sync_d = 1'b1;
                end
            end
            RD: begin
                if (wr_s) begin
                    state_d   = WR_WAIT;
                    dly_cnt_d = '0;
                end else if (!rd_s) begin
                    state_d = IDLE;
                end
            end
            WR_WAIT: begin
                // A write that ends early still produces its single pulse.
                if (!wr_s) begin
                    data_d    = dato_s;
                    we_sync_d = 1'b1;
                    state_d   = IDLE;
                end else if (dly_cnt_q == DLY_LAST) begin
                    data_d    = dato_s;
                    we_sync_d = 1'b1;
                    state_d   = WR_DONE;
                end else begin
                    dly_cnt_d = dly_cnt_q + 4'd1;
                end
            end
            WR_DONE: begin
                if (!wr_s) begin
                    state_d = IDLE;
                end
            end
            LOCK: begin
                if (!rd_s && !wr_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = LOCK;
        endcase

        // Qualifiers are registered from the next state so they line up
        // with the pulses.
        oe_d   = (state_d == RD);
        we_d   = (state_d == WR_WAIT) || (state_d == WR_DONE);
        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // Reset parks the FSM in LOCK: with idle strobes it falls to IDLE
            // on the first cycle, while a strobe held across reset is
            // swallowed instead of producing a pulse.
            state_q   <= LOCK;
            dly_cnt_q <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            oe_q      <= 1'b0;
            we_q      <= 1'b0;
            oe_sync_q <= 1'b0;
            we_sync_q <= 1'b0;
            hsm_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dly_cnt_q <= dly_cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            oe_q      <= oe_d;
            we_q      <= we_d;
            oe_sync_q <= oe_sync_d;
            we_sync_q <= we_sync_d;
            hsm_q     <= hsm_d;
            busy_q    <= busy_d;
        end
    end

    assign addr    = addr_q;
    assign data    = data_q;
    assign oe      = oe_q;
    assign we      = we_q;
    assign oe_sync = oe_sync_q;
    assign we_sync = we_sync_q;
    assign hsm     = hsm_q;
    assign busy    = busy_q;

endmodule
